// File: rtl/cell_write_arbiter.sv
// cell_write_arbiter: owns the character-memory write port. Two engines (edit, search)
// post cell writes with a req/ack handshake and are served round-robin. A built-in
// clear sweep writes a blank cell to every grid position.
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   sL                               large-char mode, selects grid bounds
//   e_req/e_x/e_y/e_ascii/e_col      edit request, held with data until e_ack
//   e_ack                            one-cycle pulse: edit request consumed
//   s_req/s_x/s_y/s_ascii/s_col      search request, same rules
//   s_ack                            one-cycle pulse: search request consumed
//   clr_req                          pulse: start clear sweep
//   clr_busy                         high while the sweep runs
//   clr_done                         one-cycle pulse after the last sweep write
//   oor                              one-cycle pulse: acked request out of range, dropped
//   wrx/wry/wren/wascii/wcolour      registered write port to memory_controller
module cell_write_arbiter #(
  parameter int unsigned COLS_S     = 80,
  parameter int unsigned ROWS_S     = 60,
  parameter int unsigned COLS_L     = 40,
  parameter int unsigned ROWS_L     = 30,
  parameter logic [6:0]  CLR_ASCII  = 7'h20,
  parameter logic [5:0]  CLR_COLOUR = 6'h3F
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sL,
  input  logic       e_req,
  input  logic [6:0] e_x,
  input  logic [5:0] e_y,
  input  logic [6:0] e_ascii,
  input  logic [5:0] e_col,
  output logic       e_ack,
  input  logic       s_req,
  input  logic [6:0] s_x,
  input  logic [5:0] s_y,
  input  logic [6:0] s_ascii,
  input  logic [5:0] s_col,
  output logic       s_ack,
  input  logic       clr_req,
  output logic       clr_busy,
  output logic       clr_done,
  output logic       oor,
  output logic [6:0] wrx,
  output logic [5:0] wry,
  output logic       wren,
  output logic [6:0] wascii,
  output logic [5:0] wcolour
);

  // Bounds are one bit wider than the counters so 128 columns / 64 rows fit.
  localparam logic [7:0] ColsS = 8'(COLS_S);
  localparam logic [6:0] RowsS = 7'(ROWS_S);
  localparam logic [7:0] ColsL = 8'(COLS_L);
  localparam logic [6:0] RowsL = 7'(ROWS_L);

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;  // 1: last grant went to search
  logic [7:0] cols_q, cols_d;
  logic [6:0] rows_q, rows_d;
  logic [6:0] cx_q, cx_d;
  logic [5:0] cy_q, cy_d;

  logic       e_ack_d, s_ack_d, oor_d, wren_d, clr_busy_d, clr_done_d;
  logic [6:0] wrx_d, wascii_d;
  logic [5:0] wry_d, wcolour_d;

  logic [7:0] cols_live;
  logic [6:0] rows_live;
  logic       elig_e, elig_s, grant_e, grant_s;
  logic [6:0] g_x, g_ascii;
  logic [5:0] g_y, g_col;
  logic       g_in_range, sweep_last_x, sweep_last;

  assign cols_live = sL ? ColsL : ColsS;
  assign rows_live = sL ? RowsL : RowsS;

  // A requester being acked this cycle still shows its old req; skip it.
  assign elig_e  = e_req & ~e_ack;
  assign elig_s  = s_req & ~s_ack;
  assign grant_e = elig_e & (~elig_s | ptr_q);
  assign grant_s = elig_s & ~grant_e;

  assign g_x        = grant_s ? s_x     : e_x;
  assign g_y        = grant_s ? s_y     : e_y;
  assign g_ascii    = grant_s ? s_ascii : e_ascii;
  assign g_col      = grant_s ? s_col   : e_col;
  assign g_in_range = ({1'b0, g_x} < cols_live) && ({1'b0, g_y} < rows_live);

  assign sweep_last_x = ({1'b0, cx_q} == cols_q - 8'd1);
  assign sweep_last   = sweep_last_x && ({1'b0, cy_q} == rows_q - 7'd1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cols_d     = cols_q;
    rows_d     = rows_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    e_ack_d    = 1'b0;
    s_ack_d    = 1'b0;
    oor_d      = 1'b0;
    wren_d     = 1'b0;
    clr_busy_d = 1'b0;
    clr_done_d = 1'b0;
    wrx_d      = wrx;
    wry_d      = wry;
    wascii_d   = wascii;
    wcolour_d  = wcolour;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d    = StClear;
          cols_d     = cols_live;
          rows_d     = rows_live;
          cx_d       = '0;
          cy_d       = '0;
          clr_busy_d = 1'b1;
        end else if (grant_e || grant_s) begin
          ptr_d   = grant_s;
          e_ack_d = grant_e;
          s_ack_d = grant_s;
          if (g_in_range) begin
            wren_d    = 1'b1;
            wrx_d     = g_x;
            wry_d     = g_y;
            wascii_d  = g_ascii;
            wcolour_d = g_col;
          end else begin
            oor_d = 1'b1;
          end
        end
      end
      StClear: begin
        wren_d    = 1'b1;
        wrx_d     = cx_q;
        wry_d     = cy_q;
        wascii_d  = CLR_ASCII;
        wcolour_d = CLR_COLOUR;
        if (sweep_last) begin
          state_d = StDone;
        end else begin
          clr_busy_d = 1'b1;
          if (sweep_last_x) begin
            cx_d = '0;
            cy_d = cy_q + 6'd1;
          end else begin
            cx_d = cx_q + 7'd1;
          end
        end
      end
      StDone: begin
        clr_done_d = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b1;
      cols_q   <= '0;
      rows_q   <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      e_ack    <= 1'b0;
      s_ack    <= 1'b0;
      oor      <= 1'b0;
      wren     <= 1'b0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      wrx      <= '0;
      wry      <= '0;
      wascii   <= '0;
      wcolour  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cols_q   <= cols_d;
      rows_q   <= rows_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      e_ack    <= e_ack_d;
      s_ack    <= s_ack_d;
      oor      <= oor_d;
      wren     <= wren_d;
      clr_busy <= clr_busy_d;
      clr_done <= clr_done_d;
      wrx      <= wrx_d;
      wry      <= wry_d;
      wascii   <= wascii_d;
      wcolour  <= wcolour_d;
    end
  end

endmodule

// File: tb/tb_cell_write_arbiter.sv
// Bench for cell_write_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model of the arbiter.
module tb_cell_write_arbiter;

  logic       clk, resetn, sL;
  logic       e_req, s_req, clr_req;
  logic [6:0] e_x, e_ascii, s_x, s_ascii;
  logic [5:0] e_y, e_col, s_y, s_col;
  logic       e_ack, s_ack, clr_busy, clr_done, oor, wren;
  logic [6:0] wrx, wascii;
  logic [5:0] wry, wcolour;

  cell_write_arbiter dut (
    .clk(clk), .resetn(resetn), .sL(sL),
    .e_req(e_req), .e_x(e_x), .e_y(e_y), .e_ascii(e_ascii), .e_col(e_col), .e_ack(e_ack),
    .s_req(s_req), .s_x(s_x), .s_y(s_y), .s_ascii(s_ascii), .s_col(s_col), .s_ack(s_ack),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .oor(oor),
    .wrx(wrx), .wry(wry), .wren(wren), .wascii(wascii), .wcolour(wcolour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a pending-grant view of the port. Phase 0 = arbitrating,
  // 1 = sweeping cell index m_idx over a cols*rows grid, 2 = sweep finished.
  int         m_phase, m_idx, m_cols, m_rows;
  bit         m_last_s;
  bit         m_eack, m_sack, m_oor, m_wren, m_busy, m_done;
  logic [6:0] m_wx, m_wa;
  logic [5:0] m_wy, m_wc;

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_cols = 0; m_rows = 0; m_last_s = 1'b1;
    m_eack = 0; m_sack = 0; m_oor = 0; m_wren = 0; m_busy = 0; m_done = 0;
    m_wx = '0; m_wy = '0; m_wa = '0; m_wc = '0;
  endtask

  task automatic model_step();
    bit ee, es, gs;
    int gx, gy, cols, rows;
    ee = e_req && !m_eack;
    es = s_req && !m_sack;
    m_eack = 0; m_sack = 0; m_oor = 0; m_wren = 0; m_busy = 0; m_done = 0;
    case (m_phase)
      0: begin
        if (clr_req) begin
          m_phase = 1; m_idx = 0;
          m_cols = sL ? 40 : 80;
          m_rows = sL ? 30 : 60;
          m_busy = 1;
        end else if (ee || es) begin
          gs = es && (!ee || !m_last_s);
          m_last_s = gs;
          m_eack = !gs; m_sack = gs;
          gx = gs ? int'(s_x) : int'(e_x);
          gy = gs ? int'(s_y) : int'(e_y);
          cols = sL ? 40 : 80;
          rows = sL ? 30 : 60;
          if (gx < cols && gy < rows) begin
            m_wren = 1;
            m_wx = 7'(gx); m_wy = 6'(gy);
            m_wa = gs ? s_ascii : e_ascii;
            m_wc = gs ? s_col : e_col;
          end else begin
            m_oor = 1;
          end
        end
      end
      1: begin
        m_wren = 1;
        m_wx = 7'(m_idx % m_cols);
        m_wy = 6'(m_idx / m_cols);
        m_wa = 7'h20; m_wc = 6'h3F;
        m_idx++;
        if (m_idx == m_cols * m_rows) m_phase = 2;
        else m_busy = 1;
      end
      default: begin
        m_done = 1;
        m_phase = 0;
      end
    endcase
  endtask

  logic [31:0] obs_v;
  assign obs_v = {e_ack, s_ack, oor, wren, clr_busy, clr_done, wrx, wry, wascii, wcolour};

  function automatic logic [31:0] exp_v();
    return {m_eack, m_sack, m_oor, m_wren, m_busy, m_done, m_wx, m_wy, m_wa, m_wc};
  endfunction

  // Observed-output tallies for the directed scenarios.
  int         wren_cnt, busy_cnt, done_cnt, eack_cnt, bad_clr_cnt;
  logic [6:0] first_x, last_x;
  logic [5:0] first_y, last_y;

  task automatic clear_tallies();
    wren_cnt = 0; busy_cnt = 0; done_cnt = 0; eack_cnt = 0; bad_clr_cnt = 0;
    first_x = '0; first_y = '0; last_x = '0; last_y = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("cycle", 64'(obs_v), 64'(exp_v()));
    if (wren) begin
      if (wren_cnt == 0) begin first_x = wrx; first_y = wry; end
      last_x = wrx; last_y = wry;
      wren_cnt++;
      if (wascii != 7'h20 || wcolour != 6'h3F) bad_clr_cnt++;
    end
    busy_cnt += int'(clr_busy);
    done_cnt += int'(clr_done);
    eack_cnt += int'(e_ack);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    e_req = 0; s_req = 0; clr_req = 0;
    model_reset();
    #1;
    check_eq("reset_outputs", 64'(obs_v), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic set_e(input bit r, input int x, input int y, input int a, input int c);
    e_req = r; e_x = 7'(x); e_y = 6'(y); e_ascii = 7'(a); e_col = 6'(c);
  endtask

  int guard;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; sL = 1'b0; clr_req = 1'b0;
    set_e(0, 0, 0, 0, 0);
    s_req = 0; s_x = '0; s_y = '0; s_ascii = '0; s_col = '0;
    model_reset();
    @(posedge clk); #1;

    // 1: single edit write, latency 1
    do_reset();
    clear_tallies();
    set_e(1, 3, 2, 'h41, 'h30);
    tick();
    check_eq("t1_ack", 64'(e_ack), 64'd1);
    check_eq("t1_data", 64'({wren, wrx, wry, wascii, wcolour}),
             64'({1'b1, 7'd3, 6'd2, 7'h41, 6'h30}));
    tick();
    e_req = 0;
    repeat (3) tick();
    check_eq("t1_one_write", 64'(wren_cnt), 64'd1);

    // 2: both requesters held, alternate starting with edit
    do_reset();
    clear_tallies();
    set_e(1, 10, 10, 'h45, 'h01);
    s_req = 1; s_x = 7'd20; s_y = 6'd20; s_ascii = 7'h53; s_col = 6'h02;
    tick();
    check_eq("t2_first_is_e", 64'({e_ack, s_ack}), 64'b10);
    repeat (7) tick();
    e_req = 0; s_req = 0;
    check_eq("t2_wren_every_cycle", 64'(wren_cnt), 64'd8);
    check_eq("t2_e_grants", 64'(eack_cnt), 64'd4);
    repeat (2) tick();

    // 3: out-of-range in large mode, in range in small mode
    sL = 1;
    set_e(1, 45, 5, 'h42, 'h11);
    tick();
    check_eq("t3_oor", 64'({e_ack, oor, wren}), 64'b110);
    e_req = 0;
    tick();
    sL = 0;
    e_req = 1;
    tick();
    check_eq("t3_inrange", 64'({e_ack, oor, wren, wrx}), 64'({3'b101, 7'd45}));
    e_req = 0;
    tick();

    // 4: large-mode sweep with edit request pending throughout
    do_reset();
    sL = 1;
    clear_tallies();
    clr_req = 1;
    set_e(1, 1, 1, 'h61, 'h05);
    tick();
    clr_req = 0;
    guard = 0;
    while (done_cnt == 0 && guard < 1400) begin tick(); guard++; end
    check_eq("t4_done_seen", 64'(done_cnt), 64'd1);
    check_eq("t4_wren_count", 64'(wren_cnt), 64'd1200);
    check_eq("t4_busy_cycles", 64'(busy_cnt), 64'd1200);
    check_eq("t4_no_ack_during", 64'(eack_cnt), 64'd0);
    check_eq("t4_first_xy", 64'({first_x, first_y}), 64'({7'd0, 6'd0}));
    check_eq("t4_last_xy", 64'({last_x, last_y}), 64'({7'd39, 6'd29}));
    check_eq("t4_clear_data", 64'(bad_clr_cnt), 64'd0);
    tick();
    check_eq("t4_ack_after", 64'({e_ack, wren, wrx, wry}), 64'({2'b11, 7'd1, 6'd1}));
    e_req = 0;
    repeat (2) tick();
    check_eq("t4_single_done", 64'(done_cnt), 64'd1);

    // 5: small-mode sweep, sL toggled mid-sweep
    do_reset();
    sL = 0;
    clear_tallies();
    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (2000) tick();
    sL = 1;
    guard = 0;
    while (done_cnt == 0 && guard < 3000) begin tick(); guard++; end
    check_eq("t5_wren_count", 64'(wren_cnt), 64'd4800);
    check_eq("t5_last_xy", 64'({last_x, last_y}), 64'({7'd79, 6'd59}));

    // 6: reset mid-sweep aborts immediately
    do_reset();
    sL = 1;
    clear_tallies();
    clr_req = 1;
    tick();
    clr_req = 0;
    guard = 0;
    while (wren_cnt < 100 && guard < 200) begin tick(); guard++; end
    check_eq("t6_reached_100", 64'(wren_cnt), 64'd100);
    #1;
    do_reset();
    clear_tallies();
    repeat (5) tick();
    check_eq("t6_no_done", 64'(done_cnt), 64'd0);
    set_e(1, 7, 7, 'h37, 'h07);
    tick();
    check_eq("t6_served", 64'({e_ack, wren, wrx, wry}), 64'({2'b11, 7'd7, 6'd7}));
    e_req = 0;
    tick();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tick();
      clr_req = (sL && $urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) sL = ~sL;
      if (!e_req || e_ack)
        set_e($urandom_range(0, 3) != 0, $urandom_range(0, 85), $urandom_range(0, 63),
              $urandom_range(0, 127), $urandom_range(0, 63));
      if (!s_req || s_ack) begin
        s_req = ($urandom_range(0, 2) != 0);
        s_x = 7'($urandom_range(0, 85));
        s_y = 6'($urandom_range(0, 63));
        s_ascii = 7'($urandom_range(0, 127));
        s_col = 6'($urandom_range(0, 63));
      end
    end
    clr_req = 0; e_req = 0; s_req = 0;
    guard = 0;
    while (m_phase != 0 && guard < 5000) begin tick(); guard++; end
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
